timer_counter: RTL and testbench

- Memory-mapped timer peripheral.
- Its read data is the PrRD source that the data-memory read mux selects for peripheral addresses.
- Two instances sit behind the system bridge: TC0 at 0x7F00–0x7F0B and TC1 at 0x7F10–0x7F1B.
- Each instance counts down from a preset value and raises an interrupt request to CP0.
- Supports one-shot and auto-reload modes.

---
 rtl/timer_counter_pkg.sv | 35 +++
 rtl/timer_counter_if.sv | 14 +
 rtl/timer_counter.sv | 105 ++++++++++
 tb/tb_timer_counter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, mode codes and the CTRL register layout.
package timer_counter_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // CTRL bit layout: [3] IM, [2:1] MODE, [0] EN.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  // Only the exact auto-reload code reloads; every other MODE value is one-shot.
  function automatic logic is_reload(input tc_ctrl_t c);
    return (c.mode == MODE_RELOAD) && (c.mode != MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Peripheral-side register bus of one timer instance, as seen behind the bridge.
interface timer_counter_if;
  import timer_counter_pkg::*;

  logic [1:0]        addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);

endinterface

// File: rtl/timer_counter.sv
// Countdown timer with one-shot / auto-reload modes, a maskable interrupt flag
// and a zero-latency combinational register read port.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  tc_state_e        state_q, state_d;
  tc_ctrl_t         ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;
  logic             flag_set;
  logic             wr_ctrl;
  logic             wr_preset;

  assign wr_ctrl   = bus.we && (bus.addr == OFF_CTRL);
  assign wr_preset = bus.we && (bus.addr == OFF_PRESET);

  always_comb begin
    // NOTE: every target is given its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    flag_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_q)) flag_d = 1'b0;
        else                   ctrl_d.en = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Software writes override the hardware EN clear; a flag set this cycle
    // overrides the software clear so an interrupt is never lost.
    if (wr_ctrl) begin
      ctrl_d = tc_ctrl_t'(bus.wdata[CTRL_W-1:0]);
      flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = bus.wdata[CNT_W-1:0];
      flag_d   = 1'b0;
    end
    if (flag_set) flag_d = 1'b1;
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      OFF_CTRL:   bus.rdata = DATA_W'(ctrl_q);
      OFF_PRESET: bus.rdata = DATA_W'(preset_q);
      OFF_COUNT:  bus.rdata = DATA_W'(count_q);
      OFF_RSVD:   bus.rdata = '0;
    endcase
  end

  assign bus.irq = flag_q & ctrl_q.im;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// register traffic compared against a timeline-based reference model.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_counter_if bus ();

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline of edges counted from the edge that
  // leaves idle (k=0). Edge k=1 loads, the flag fires at edge 1+max(P,1),
  // the following edge acknowledges, and EN=0 on any counting edge freezes.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_load;
  logic        m_flag;
  bit          m_active;
  int          m_k;

  task automatic model_reset();
    m_ctrl = '0; m_preset = '0; m_count = '0; m_load = '0;
    m_flag = 1'b0; m_active = 0; m_k = 0;
  endtask

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
    int kf;
    bit fire;
    fire = 0;
    if (!m_active) begin
      if (m_ctrl[0]) begin m_active = 1; m_k = 0; end
    end else begin
      m_k++;
      if (m_k == 1) begin
        m_load  = m_preset;
        m_count = m_preset;
      end else begin
        kf = 1 + ((m_load > 32'd1) ? int'(m_load) : 1);
        if (m_k <= kf) begin
          if (!m_ctrl[0])    m_active = 0;
          else if (m_k < kf) m_count = m_load - 32'(m_k - 1);
          else begin m_count = '0; fire = 1; end
        end else begin
          if (m_ctrl[2:1] == 2'b01) m_flag = 1'b0;
          else                      m_ctrl[0] = 1'b0;
          m_active = 0;
        end
      end
    end
    if (w && a == 2'd0) begin m_ctrl = d[3:0]; m_flag = 1'b0; end
    if (w && a == 2'd1) begin m_preset = d;    m_flag = 1'b0; end
    if (fire) m_flag = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_irq();
    return m_flag & m_ctrl[3];
  endfunction

  // One clock: apply a bus cycle, advance the model at the edge, check irq #1 later.
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
    bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    model_edge(w, a, d);
    #1;
    bus.we = 1'b0;
    check("irq", {31'b0, bus.irq}, {31'b0, model_irq()});
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 32'd0);
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    bus.we = 1'b0; bus.addr = a;
    #1;
    v = bus.rdata;
    check($sformatf("rdata@%0d", a), v, model_read(a));
  endtask

  // Reset pulse placed between edges; the effect must be visible with no clock edge.
  task automatic async_reset();
    logic [31:0] v;
    #2 reset = 1'b0;
    #1 model_reset();
    check("rst_irq", {31'b0, bus.irq}, 32'd0);
    peek(2'd2, v);
    check("rst_count", v, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int hits[$];
    bit found;
    logic       w;
    logic [1:0] a;
    logic [31:0] d;

    reset = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    model_reset();
    #12;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), v);
      check("reset_rd", v, 32'd0);
    end
    check("reset_irq", {31'b0, bus.irq}, 32'd0);

    // One-shot, PRESET=3
    step(1'b1, 2'd1, 32'd3);
    step(1'b1, 2'd0, 32'h9);
    for (int e = 1; e <= 5; e++) begin
      idle();
      if (e >= 2) begin
        peek(2'd2, v);
        check("os_count", v, 32'(5 - e));
      end
      check("os_irq", {31'b0, bus.irq}, {31'b0, (e == 5)});
    end
    idle();
    peek(2'd0, v);
    check("os_ctrl", v, 32'h8);
    idle();
    check("os_irq_hold", {31'b0, bus.irq}, 32'd1);
    step(1'b1, 2'd0, 32'h8);
    check("os_irq_clr", {31'b0, bus.irq}, 32'd0);

    // Auto-reload, PRESET=2: pulses at edges 4, 9, 14, 19 after the CTRL write
    async_reset();
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'hB);
    for (int e = 1; e <= 22; e++) begin
      idle();
      if (bus.irq) hits.push_back(e);
    end
    check("ar_npulse", 32'(hits.size()), 32'd4);
    if (hits.size() > 0) check("ar_first", 32'(hits[0]), 32'd4);
    for (int i = 1; i < hits.size(); i++) check("ar_period", 32'(hits[i] - hits[i-1]), 32'd5);
    peek(2'd0, v);
    check("ar_ctrl", v, 32'hB);
    step(1'b1, 2'd0, 32'h0);

    // Mask: flag sets with IM=0, then a CTRL write clears it
    async_reset();
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'h1);
    for (int e = 1; e <= 4; e++) begin
      idle();
      check("mask_irq", {31'b0, bus.irq}, 32'd0);
    end
    step(1'b1, 2'd0, 32'h9);
    check("mask_wr_irq", {31'b0, bus.irq}, 32'd0);

    // Pause at COUNT=6, then resume reloads 10
    async_reset();
    step(1'b1, 2'd1, 32'd10);
    step(1'b1, 2'd0, 32'h9);
    found = 0;
    for (int e = 0; e < 30 && !found; e++) begin
      idle();
      peek(2'd2, v);
      if (v == 32'd6) found = 1;
    end
    check("pause_reach6", {31'b0, found}, 32'd1);
    step(1'b1, 2'd0, 32'h8);
    for (int e = 0; e < 4; e++) begin
      idle();
      peek(2'd2, v);
      check("pause_hold", v, 32'd5);
      check("pause_irq", {31'b0, bus.irq}, 32'd0);
    end
    step(1'b1, 2'd0, 32'h9);
    idle();
    idle();
    peek(2'd2, v);
    check("pause_reload", v, 32'd10);

    // PRESET=0 fires 3 edges after enable; read-only and reserved offsets
    async_reset();
    step(1'b1, 2'd1, 32'd0);
    step(1'b1, 2'd0, 32'h9);
    for (int e = 1; e <= 3; e++) begin
      idle();
      check("p0_irq", {31'b0, bus.irq}, {31'b0, (e == 3)});
    end
    idle();
    step(1'b1, 2'd2, 32'h55);
    peek(2'd2, v);
    check("ro_count", v, 32'd0);
    step(1'b1, 2'd3, 32'hFFFF_FFFF);
    peek(2'd3, v);
    check("rsvd_rd", v, 32'd0);

    // Async reset mid-count and with irq asserted
    step(1'b1, 2'd1, 32'd20);
    step(1'b1, 2'd0, 32'h9);
    for (int e = 0; e < 6; e++) idle();
    peek(2'd2, v);
    async_reset();
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'h9);
    for (int e = 0; e < 3; e++) idle();
    check("pre_rst_irq", {31'b0, bus.irq}, 32'd1);
    async_reset();

    // Randomized register traffic
    for (int c = 0; c < 3000; c++) begin
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      step(w, a, d);
      if ($urandom_range(0, 599) == 0) async_reset();
      peek(2'($urandom_range(0, 3)), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
